// File: rtl/fp_pkg.sv
// Shared single-precision float definitions: field widths, bias, control
// state encoding and the {sign, exp, man} pack helper.
package fp_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StNorm = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic [EXP_W+MAN_W:0] pack_float(input logic             sign,
                                                     input logic [EXP_W-1:0] exp,
                                                     input logic [MAN_W-1:0] man);
    return {sign, exp, man};
  endfunction

endpackage

// File: rtl/norm_shift_reg.sv
// Magnitude register with load / shift-left-by-one, plus the exponent
// down-counter that tracks each shift.
module norm_shift_reg #(
  parameter int unsigned INT_W = 32,
  parameter int unsigned EXP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [INT_W-1:0]   load_mag,
  input  logic [EXP_W-1:0]   load_exp,
  output logic               msb,
  output logic [INT_W-10:0]  man,
  output logic [EXP_W-1:0]   exp
);

  logic [INT_W-1:0] mag_q;
  logic [EXP_W-1:0] exp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q <= '0;
      exp_q <= '0;
    end else if (load) begin
      mag_q <= load_mag;
      exp_q <= load_exp;
    end else if (shift) begin
      mag_q <= mag_q << 1;
      exp_q <= exp_q - 1'b1;
    end
  end

  assign msb = mag_q[INT_W-1];
  // Hidden bit dropped; the low 8 bits are truncated (round toward zero).
  assign man = mag_q[INT_W-2:8];
  assign exp = exp_q;

endmodule

// File: rtl/int_to_float_seq.sv
// Sequential signed int32 -> IEEE-754 single converter: abs, normalise one bit
// per cycle, then pack. start/done handshake, start accepted only when idle.
module int_to_float_seq
  import fp_pkg::*;
#(
  parameter int unsigned INT_W    = 32,
  parameter int unsigned EXP_BIAS = fp_pkg::EXP_BIAS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [INT_W-1:0] intIn,
  output logic             busy,
  output logic             done,
  output logic [INT_W-1:0] floatOut
);

  state_e             state_q;
  logic               sign_q;
  logic [INT_W-1:0]   abs_mag;
  logic               int_zero;
  logic               load;
  logic               shift;
  logic               msb;
  logic [MAN_W-1:0]   man;
  logic [EXP_W-1:0]   exp;

  localparam logic [EXP_W-1:0] ExpStart = EXP_W'(EXP_BIAS + INT_W - 1);

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign abs_mag  = intIn[INT_W-1] ? (~intIn + 1'b1) : intIn;
  assign int_zero = (intIn == '0);
  assign load     = (state_q == StIdle) && start;
  assign shift    = (state_q == StNorm) && !msb;

  norm_shift_reg #(
    .INT_W (INT_W),
    .EXP_W (EXP_W)
  ) u_norm (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .load_mag (abs_mag),
    .load_exp (ExpStart),
    .msb      (msb),
    .man      (man),
    .exp      (exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      floatOut <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sign_q <= intIn[INT_W-1];
            busy   <= 1'b1;
            if (int_zero) begin
              state_q  <= StDone;
              done     <= 1'b1;
              floatOut <= '0;
            end else begin
              state_q <= StNorm;
            end
          end
        end
        StNorm: begin
          if (msb) begin
            state_q  <= StDone;
            done     <= 1'b1;
            floatOut <= pack_float(sign_q, exp, man);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float_seq.sv
// Self-checking bench for int_to_float_seq: directed cases, handshake and reset
// behaviour, then random operands against an arithmetic reference model.
module tb_int_to_float_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] intIn = '0;
  logic        busy;
  logic        done;
  logic [31:0] floatOut;

  int n_total = 0;
  int n_pass  = 0;

  int_to_float_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .intIn    (intIn),
    .busy     (busy),
    .done     (done),
    .floatOut (floatOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  function automatic int top_bit(input longint m);
    int p = 0;
    for (int i = 0; i < 33; i++) if (m >= (longint'(1) << i)) p = i;
    return p;
  endfunction

  function automatic longint abs_val(input logic [31:0] v);
    int     iv;
    longint m;
    iv = v;
    m  = iv;
    return (m < 0) ? -m : m;
  endfunction

  // Value = 2^p * (1 + frac/2^23), fraction truncated.
  function automatic logic [31:0] ref_float(input logic [31:0] v);
    longint m;
    longint frac;
    int     p;
    if (v == 0) return 32'h0;
    m    = abs_val(v);
    p    = top_bit(m);
    frac = m - (longint'(1) << p);
    if (p >= 23) frac = frac >> (p - 23);
    else         frac = frac << (23 - p);
    return {v[31], 8'(127 + p), 23'(frac)};
  endfunction

  // k leading zeros -> done k+2 cycles after the accepting edge; zero -> 1.
  function automatic int ref_lat(input logic [31:0] v);
    if (v == 0) return 1;
    return (31 - top_bit(abs_val(v))) + 2;
  endfunction

  task automatic run_conv(input logic [31:0] v, input logic [31:0] exp_f, input int exp_lat,
                          input string tag, input bit spam);
    int   lat     = 0;
    bit   seen    = 0;
    bit   busy_ok = 1;
    logic [31:0] held;
    @(negedge clk);
    intIn = v;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (!spam) start = 1'b0;
      intIn = $urandom;
      if (busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) begin
        seen = 1;
        lat  = c;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " value"}, floatOut, exp_f);
    check({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
    held = floatOut;
    // start still high during the done cycle when spamming: must be ignored.
    @(negedge clk);
    start = 1'b0;
    check({tag, " idle busy"}, {31'b0, busy}, 32'd0);
    check({tag, " single done"}, {31'b0, done}, 32'd0);
    @(negedge clk);
    check({tag, " held"}, floatOut, held);
  endtask

  initial begin
    logic [31:0] v;
    bit          no_done;

    #2;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset float", floatOut, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_conv(32'h0000_0001, 32'h3F80_0000, 33, "one", 0);
    run_conv(32'hFFFF_FFFF, 32'hBF80_0000, 33, "minus_one", 0);
    run_conv(32'd10,        32'h4120_0000, 30, "ten", 0);
    run_conv(32'h8000_0000, 32'hCF00_0000, 2,  "int_min", 0);
    run_conv(32'h7FFF_FFFF, 32'h4EFF_FFFF, 3,  "int_max", 0);
    run_conv(32'h0000_0000, 32'h0000_0000, 1,  "zero", 0);
    run_conv(32'h0100_0001, 32'h4B80_0000, 9,  "trunc", 0);
    run_conv(32'd5,         32'h40A0_0000, 31, "spam_five", 1);

    // Async reset in the middle of normalisation.
    @(negedge clk);
    intIn = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort float", floatOut, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    no_done = 1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) no_done = 0;
    end
    check("abort no done", {31'b0, no_done}, 32'd1);
    run_conv(32'd10, 32'h4120_0000, 30, "after_reset", 0);

    for (int i = 0; i < 24; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      run_conv(v, ref_float(v), ref_lat(v), "random", 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/int_to_float_seq.md
Name: int_to_float_seq

Overview:
Multi-cycle converter from a signed 32-bit two's-complement integer to an IEEE-754 single-precision float. It is the packing counterpart to the float adder datapath, which unpacks sign, exponent and mantissa and works on magnitudes. This block takes a magnitude, normalises it with a one-bit-per-cycle shift register and an exponent down-counter, then packs sign, exponent and mantissa. It feeds integer operands into the adder and sits beside it in the same control/datapath style, with a start/done handshake.

Parameters:
INT_W, 32, integer input width; only 32 is supported, kept for readability of width expressions.
EXP_BIAS, 127, single-precision exponent bias.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request conversion of intIn; sampled only in IDLE.
intIn  input  32  signed two's-complement operand.
busy  output  1  high while a conversion is in progress (NORM and DONE states).
done  output  1  one-cycle pulse; floatOut is valid from this cycle.
floatOut  output  32  result {sign, exp[7:0], man[22:0]}; held until the next done.

Behaviour:
- Reset, asynchronous, active-high. State goes to IDLE and busy, done, floatOut, sign, mag and exp all clear to 0.
- Reset mid-conversion aborts the conversion. No done is generated. floatOut is 0 after reset.
- FSM states are IDLE, NORM and DONE.
- IDLE, with start=1 at edge T:
  - Latch sign = intIn[31].
  - Latch mag[31:0] = sign ? (~intIn + 1) : intIn, as unsigned. intIn = 0x80000000 gives mag = 0x80000000.
  - Load exp = EXP_BIAS + 31 = 158.
  - If intIn == 0, go to DONE with a zero flag set. Otherwise go to NORM.
- NORM, one cycle per step:
  - If mag[31] == 1, go to DONE.
  - Otherwise mag <= mag << 1 and exp <= exp - 1.
  - There are at most 31 shifts. exp never drops below 127, so there is no underflow.
- DONE, one cycle:
  - done = 1 and busy = 1.
  - floatOut is registered on entry to DONE as {sign, exp, mag[30:8]}, or 32'h0000_0000 when the zero flag is set.
  - Next state is IDLE.
- Latency, with k = number of leading zeros of mag:
  - done is asserted in cycle T+k+2.
  - For intIn = 0, done is asserted in cycle T+1.
- Rounding is toward zero: mag[7:0] is discarded. Results are therefore exact for |intIn| < 2^24.
- Sign of zero: intIn = 0 yields +0 only.
- Handshake:
  - start while busy=1 is ignored and not queued.
  - start in the same cycle as done is also ignored, because the state is DONE, not IDLE.
  - start is accepted again from the first IDLE cycle after done.
- intIn is sampled only at the accepting edge. Changes during NORM have no effect.
- The exponent path is 8 bits unsigned. The magnitude path is 32 bits unsigned.

Decomposition:
- Shared package (fp_pkg) holds:
  - EXP_BIAS.
  - Field widths: EXP_W=8, MAN_W=23.
  - The FSM state encoding: IDLE=2'd0, NORM=2'd1, DONE=2'd2.
  - A pack helper for the {sign, exp, man} layout, also used by the adder's output path.
- One sub-module, norm_shift_reg. It is the 32-bit magnitude register with load and shift-left-by-1 enable, plus the 8-bit exponent down-counter. It exposes msb = mag[31].
- The top level holds the FSM, the abs/negate logic, the zero detect and the floatOut register.

Test Plan:
- intIn=1, start at T -> done at T+33, floatOut=0x3F800000; busy high T+1..T+33.
- intIn=0xFFFFFFFF (-1) -> floatOut=0xBF800000. intIn=10 -> 0x41200000, done at T+30.
- intIn=0x80000000 -> k=0, done at T+2, floatOut=0xCF000000. intIn=0x7FFFFFFF -> 0x4EFFFFFF (truncated).
- intIn=0 -> done at T+1, floatOut=0x00000000. Then intIn=0x01000001 -> 0x4B800000, showing toward-zero rounding.
- start pulsed every cycle during a conversion of intIn=5 -> exactly one done; result 0x40A00000; the next start is accepted only in IDLE.
- rst asserted asynchronously mid-NORM -> busy, done and floatOut go to 0 immediately with no done pulse. A new start after reset release converts normally.
